// File: rtl/fifo_ser_pkg.sv
// Shared types and helpers for the FIFO read serializer.
package fifo_ser_pkg;

    typedef enum logic {SER_IDLE, SER_SEND} ser_state_t;

    function automatic int unsigned beat_cnt_width(input int unsigned ratio);
        return (ratio > 32'd1) ? 32'($clog2(ratio)) : 32'd1;
    endfunction

endpackage

// File: rtl/fifo_read_serializer.sv
// Pops words from a FIFO read port and streams them as OUT_WIDTH-bit beats on valid/ready.
// Define FIFO_SER_PARITY_EN to add the out_parity output.
module fifo_read_serializer
    import fifo_ser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic                  clk_in,
    input  logic                  areset,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_last,
`ifdef FIFO_SER_PARITY_EN
    output logic                  out_parity,
`endif
    output logic                  busy
);

    localparam int unsigned RATIO = DATA_WIDTH / OUT_WIDTH;
    localparam int unsigned CNT_W = beat_cnt_width(RATIO);

    if ((DATA_WIDTH % OUT_WIDTH) != 0 || OUT_WIDTH > DATA_WIDTH) begin : g_bad_cfg
        $error("fifo_read_serializer: DATA_WIDTH must be a non-zero multiple of OUT_WIDTH");
    end

    ser_state_t              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   word_q;
    logic [CNT_W-1:0]        beat_sel;
    logic                    beat_acc;
    logic [OUT_WIDTH-1:0]    slices [RATIO];

    for (genvar g = 0; g < RATIO; g++) begin : g_slice
        assign slices[g] = word_q[g*OUT_WIDTH +: OUT_WIDTH];
    end

    assign out_valid = (state_q == SER_SEND);
    assign busy      = out_valid;
    assign out_last  = (cnt_q == CNT_W'(RATIO - 1)) && out_valid;
    assign beat_acc  = out_valid && out_ready;
    assign beat_sel  = MSB_FIRST ? (CNT_W'(RATIO - 1) - cnt_q) : cnt_q;
    assign out_data  = out_valid ? slices[beat_sel] : '0;

    // Refill on the last accepted beat so a queued word follows without a bubble.
    assign fifo_rd = !areset && !fifo_empty && ((state_q == SER_IDLE) || (beat_acc && out_last));

`ifdef FIFO_SER_PARITY_EN
    assign out_parity = out_valid & (^out_data);
`endif

    // A pop outranks the last-beat return to idle.
    always_ff @(posedge clk_in or posedge areset) begin
        if (areset) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
        end else if (fifo_rd) begin
            state_q <= SER_SEND;
            cnt_q   <= '0;
            word_q  <= fifo_data;
        end else if (beat_acc) begin
            if (out_last) begin
                state_q <= SER_IDLE;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
